// File: rtl/ascii_calc_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ascii_calc_pkg
// Purpose : Shared token codes, error codes, ASCII constants and FSM states
//           for the ASCII calculator front end.
// Revision: 1.0 - initial release
// ============================================================================
package ascii_calc_pkg;

    localparam logic [1:0] TOK_NUM = 2'd0;
    localparam logic [1:0] TOK_OP  = 2'd1;
    localparam logic [1:0] TOK_END = 2'd2;
    localparam logic [1:0] TOK_ERR = 2'd3;

    localparam logic [1:0] ERR_ILLEGAL = 2'd1;
    localparam logic [1:0] ERR_OVF     = 2'd2;

    localparam logic [7:0] ASCII_NUL  = 8'h00;
    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_NINE = 8'h39;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FRAME  = 3'd1,
        ST_NUMBER = 3'd2,
        ST_EMIT2  = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

    // Operators understood by the evaluation stage: * + / < = >
    function automatic logic is_math_symbol(input logic [7:0] c);
        return (c == 8'h2A) || (c == 8'h2B) || (c == 8'h2F) ||
               (c == 8'h3C) || (c == 8'h3D) || (c == 8'h3E);
    endfunction

endpackage : ascii_calc_pkg
`default_nettype wire

// File: rtl/ascii_token_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module  : ascii_token_sequencer_if
// Purpose : Byte-in / token-out handshake bundle of the token sequencer.
// Revision: 1.0 - initial release
// ============================================================================
interface ascii_token_sequencer_if #(
    parameter int VALUE_W = 16
);

    logic               in_valid;
    logic [7:0]         in_data;
    logic               in_ready;
    logic               tok_valid;
    logic               tok_ready;
    logic [1:0]         tok_type;
    logic [VALUE_W-1:0] tok_value;
    logic [7:0]         tok_op;
    logic               busy;

    modport master (
        output in_valid,
        output in_data,
        output tok_ready,
        input  in_ready,
        input  tok_valid,
        input  tok_type,
        input  tok_value,
        input  tok_op,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  tok_ready,
        output in_ready,
        output tok_valid,
        output tok_type,
        output tok_value,
        output tok_op,
        output busy
    );

endinterface : ascii_token_sequencer_if
`default_nettype wire

// File: rtl/ascii_type_detector.sv
`default_nettype none
// ============================================================================
// Module  : ascii_type_detector
// Purpose : Combinational classifier of one ASCII byte (digit/operator/NUL).
// Revision: 1.0 - initial release
// ============================================================================
module ascii_type_detector
    import ascii_calc_pkg::*;
(
    input  logic [7:0] data,
    output logic       number,
    output logic       math_symbol,
    output logic       start_stop
);

    assign number      = (data >= ASCII_ZERO) && (data <= ASCII_NINE);
    assign math_symbol = is_math_symbol(data);
    assign start_stop  = (data == ASCII_NUL);

endmodule : ascii_type_detector
`default_nettype wire

// File: rtl/ascii_token_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : ascii_token_sequencer
// Purpose : Frames NUL-delimited ASCII expressions into NUM/OP/END/ERR tokens.
// Revision: 1.0 - initial release
// ============================================================================
module ascii_token_sequencer
    import ascii_calc_pkg::*;
#(
    parameter int VALUE_W = 16
)(
    input  logic                    clk,
    input  logic                    rst_n,
    ascii_token_sequencer_if.slave  bus
);

    localparam int WIDE_W = VALUE_W + 4;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [VALUE_W-1:0] r_acc;
    logic [VALUE_W-1:0] w_acc_nxt;
    logic [1:0]         r_held_type;
    logic [1:0]         w_held_type_nxt;
    logic [7:0]         r_held_op;
    logic [7:0]         w_held_op_nxt;
    logic [1:0]         r_err_code;
    logic [1:0]         w_err_code_nxt;
    logic [7:0]         r_err_byte;
    logic [7:0]         w_err_byte_nxt;

    logic               r_tok_valid;
    logic [1:0]         r_tok_type;
    logic [VALUE_W-1:0] r_tok_value;
    logic [7:0]         r_tok_op;

    logic               w_load;
    logic [1:0]         w_load_type;
    logic [VALUE_W-1:0] w_load_value;
    logic [7:0]         w_load_op;

    logic               w_is_num;
    logic               w_is_op;
    logic               w_is_nul;
    logic               w_free;
    logic               w_accept;
    logic [WIDE_W-1:0]  w_wide;
    logic               w_ovf;

    ascii_type_detector u_type_detector (
        .data        (bus.in_data),
        .number      (w_is_num),
        .math_symbol (w_is_op),
        .start_stop  (w_is_nul)
    );

    // The output register is free when empty or being consumed this cycle.
    assign w_free       = !r_tok_valid || bus.tok_ready;
    assign bus.in_ready = (r_state != ST_EMIT2) && w_free;
    assign w_accept     = bus.in_valid && bus.in_ready;

    // Four spare bits hold value*10+9 exactly, so overflow is any upper bit set.
    assign w_wide = (WIDE_W'(r_acc) * WIDE_W'(10)) + WIDE_W'(bus.in_data[3:0]);
    assign w_ovf  = |w_wide[WIDE_W-1:VALUE_W];

    assign bus.tok_valid = r_tok_valid;
    assign bus.tok_type  = r_tok_type;
    assign bus.tok_value = r_tok_value;
    assign bus.tok_op    = r_tok_op;
    assign bus.busy      = (r_state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_acc       <= '0;
            r_held_type <= TOK_END;
            r_held_op   <= '0;
            r_err_code  <= '0;
            r_err_byte  <= '0;
            r_tok_valid <= 1'b0;
            r_tok_type  <= TOK_NUM;
            r_tok_value <= '0;
            r_tok_op    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_acc       <= w_acc_nxt;
            r_held_type <= w_held_type_nxt;
            r_held_op   <= w_held_op_nxt;
            r_err_code  <= w_err_code_nxt;
            r_err_byte  <= w_err_byte_nxt;
            if (w_load) begin
                r_tok_valid <= 1'b1;
                r_tok_type  <= w_load_type;
                r_tok_value <= w_load_value;
                r_tok_op    <= w_load_op;
            end else if (bus.tok_ready) begin
                r_tok_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_acc_nxt       = r_acc;
        w_held_type_nxt = r_held_type;
        w_held_op_nxt   = r_held_op;
        w_err_code_nxt  = r_err_code;
        w_err_byte_nxt  = r_err_byte;
        w_load          = 1'b0;
        w_load_type     = TOK_NUM;
        w_load_value    = '0;
        w_load_op       = '0;

        case (r_state)
            ST_IDLE: begin
                if (w_accept && w_is_nul) begin
                    w_state_nxt = ST_FRAME;
                end
            end

            ST_FRAME: begin
                if (w_accept) begin
                    if (w_is_num) begin
                        w_acc_nxt   = VALUE_W'(bus.in_data[3:0]);
                        w_state_nxt = ST_NUMBER;
                    end else if (w_is_op) begin
                        w_load      = 1'b1;
                        w_load_type = TOK_OP;
                        w_load_op   = bus.in_data;
                    end else if (w_is_nul) begin
                        w_load      = 1'b1;
                        w_load_type = TOK_END;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_err_code_nxt = ERR_ILLEGAL;
                        w_err_byte_nxt = bus.in_data;
                        w_state_nxt    = ST_ERROR;
                    end
                end
            end

            ST_NUMBER: begin
                if (w_accept) begin
                    if (w_is_num) begin
                        if (w_ovf) begin
                            w_err_code_nxt = ERR_OVF;
                            w_err_byte_nxt = bus.in_data;
                            w_state_nxt    = ST_ERROR;
                        end else begin
                            w_acc_nxt = w_wide[VALUE_W-1:0];
                        end
                    end else if (w_is_op || w_is_nul) begin
                        // NUM goes out now; the operator or END waits one slot.
                        w_load          = 1'b1;
                        w_load_type     = TOK_NUM;
                        w_load_value    = r_acc;
                        w_held_type_nxt = w_is_op ? TOK_OP : TOK_END;
                        w_held_op_nxt   = w_is_op ? bus.in_data : 8'h00;
                        w_state_nxt     = ST_EMIT2;
                    end else begin
                        w_err_code_nxt = ERR_ILLEGAL;
                        w_err_byte_nxt = bus.in_data;
                        w_state_nxt    = ST_ERROR;
                    end
                end
            end

            ST_EMIT2: begin
                if (w_free) begin
                    w_load      = 1'b1;
                    w_load_type = r_held_type;
                    w_load_op   = r_held_op;
                    w_state_nxt = (r_held_type == TOK_OP) ? ST_FRAME : ST_IDLE;
                end
            end

            ST_ERROR: begin
                if (w_accept && w_is_nul) begin
                    w_load       = 1'b1;
                    w_load_type  = TOK_ERR;
                    w_load_value = VALUE_W'(r_err_code);
                    w_load_op    = r_err_byte;
                    w_state_nxt  = ST_IDLE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule : ascii_token_sequencer
`default_nettype wire

// File: doc/ascii_token_sequencer.md
# ascii_token_sequencer

Frame-level controller that sequences the ASCII classifier over a byte stream and turns it into calculator tokens. It accepts one ASCII byte per valid/ready handshake and classifies it with the ascii_type_detector instance. It accumulates decimal digits into a value, frames expressions between NUL bytes, and emits NUM / OP / END / ERR tokens downstream over a second valid/ready handshake. It sits between the character source (UART/keyboard front end) and the calculator evaluation stage.

## Interface
- VALUE_W, 16, width of accumulated unsigned number
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  input byte valid
- in_data  in  8  input ASCII byte
- in_ready  out  1  byte accepted when in_valid && in_ready
- tok_valid  out  1  token valid (registered)
- tok_ready  in  1  downstream accepts token when tok_valid && tok_ready
- tok_type  out  2  0 NUM, 1 OP, 2 END, 3 ERR
- tok_value  out  VALUE_W  NUM: number; ERR: error code (1 illegal char, 2 overflow); else 0
- tok_op  out  8  OP: operator ASCII; ERR: offending byte; else 0
- busy  out  1  high whenever state != IDLE

## Operation
- States: IDLE, FRAME, NUMBER, EMIT2, ERROR.
- IDLE: all bytes are accepted. NUL -> FRAME. Any other byte is discarded and produces no token.
- FRAME (no digits pending):
  - digit -> value = digit, go to NUMBER.
  - op (* + / < = >) -> emit OP.
  - NUL -> emit END, go to IDLE.
  - other byte -> latch it as the offending byte with code 1, go to ERROR.
- NUMBER:
  - digit -> value = value*10 + (byte-48). If the true result exceeds 2^VALUE_W-1, latch the digit with code 2 and go to ERROR.
  - op -> emit NUM(value), hold the op byte, go to EMIT2.
  - NUL -> emit NUM(value), hold END, go to EMIT2.
  - other byte -> code 1, go to ERROR. The pending number is discarded.
- EMIT2: in_ready=0. When the output register frees, emit the held token. Then go to FRAME (after an op) or IDLE (after END).
- ERROR: all bytes are accepted and discarded until NUL. On NUL, emit ERR with the latched code and byte, then go to IDLE. No END follows an ERR.
- Only the first error in a frame is recorded.
- Leading zeros are legal. An empty frame (NUL NUL) emits END only. No grammar check: adjacent ops are passed through.
- Overflow check uses a VALUE_W+4-bit intermediate. Equality with 2^VALUE_W-1 is legal.

## Timing
- Reset values: tok_valid=0, tok_type=0, tok_value=0, tok_op=0, busy=0, state=IDLE, accumulator=0. in_ready=1 in the first cycle after reset.
- Reset mid-frame drops any pending or held token and any partial number. No END is emitted.
- in_ready = (state != EMIT2) && (!tok_valid || tok_ready). This is combinational.
- Latency: a token appears on tok_valid one cycle after the accepting handshake.
- One token register. A token is loaded in the same cycle the previous one is consumed, so full throughput is 1 byte/cycle with tok_ready held high.
- Byte that yields two tokens (op or NUL after a digit): NUM at cycle N+1, held token no earlier than N+2. in_ready stays 0 until the held token is loaded.
- While tok_valid && !tok_ready: tok_type, tok_value and tok_op are stable and no byte is accepted.
- Bytes that emit nothing (discard in IDLE/ERROR, digit accumulation) are accepted whenever in_ready=1.

## Structure
- Package ascii_calc_pkg holds:
  - token type codes TOK_NUM/OP/END/ERR
  - error codes ERR_ILLEGAL=1, ERR_OVF=2
  - ASCII_NUL=0, ASCII_ZERO=48
  - state encoding
- Sub-module: one ascii_type_detector instance on in_data, supplying number, math_symbol and start_stop.
- Everything else is one FSM plus the accumulator, held-token register and output register in ascii_token_sequencer.

## Test plan
- NUL "12+3" NUL, tok_ready=1 -> tokens NUM 12, OP 43, NUM 3, END. Back-to-back, with in_ready low exactly one cycle after '+' and after the final NUL.
- Same stream, tok_ready low 5 cycles while NUM 12 is valid -> in_ready=0 and tok fields constant for those cycles. Token sequence is unchanged, with no loss or duplication.
- VALUE_W=16:
  - NUL "65535" NUL -> NUM 65535, END.
  - NUL "65536" NUL -> single ERR, tok_value=2, tok_op=0x36.
- NUL "1a2*" NUL -> single ERR, tok_value=1, tok_op=0x61. No NUM or OP emitted, busy=0 afterwards.
- "7" NUL NUL -> only END. The '7' is discarded in IDLE.
- Reset (rst_n=0 one cycle) after NUL "9", then NUL "5" NUL -> outputs at reset values, then NUM 5, END. No token is derived from the 9.
